// File: rtl/truncate_sequencer_pkg.sv
// truncate_sequencer_pkg: shared FSM encoding, default parameters and saturating increment
package truncate_sequencer_pkg;
  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_HUNT     = 2'd1;
  localparam logic [1:0] ST_LOCKED   = 2'd2;
  localparam int RATIO_DEF      = 4;
  localparam int LOCK_COUNT_DEF = 8;
  localparam int BX_MAX_DEF     = 3563;
  localparam int CNT_W_DEF      = 16;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
    return (v == max) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/truncate_sequencer_phase.sv
// frame_phase_detect: samples frame_clock, tracks the fast-clock phase and qualifies lock
//   clock/reset   fabric clock, async active-high reset
//   frame_clock   frame clock sampled as data
//   ph            phase within the frame (0 on the cycle an aligned edge is seen)
//   locked        frame phase locked
//   slip          one-cycle pulse in the cycle lock is lost
module frame_phase_detect
  import truncate_sequencer_pkg::*;
#(
  parameter int RATIO      = RATIO_DEF,
  parameter int LOCK_COUNT = LOCK_COUNT_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     frame_clock,
  output logic [$clog2(RATIO)-1:0] ph,
  output logic                     locked,
  output logic                     slip
);
  localparam int PW = $clog2(RATIO);
  localparam int LW = $clog2(LOCK_COUNT + 1);
  logic [1:0] rs_q;
  logic fc0_q;
  logic [1:0] fc_q;
  logic [1:0] st_q, st_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [LW-1:0] run_q, run_d;
  logic lk_q, lk_d;
  logic fe, ph0;
  // first sampler stage is deliberately unreset: it only ever holds a sample of an async input
  always_ff @(posedge clock) fc0_q <= frame_clock;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rs_q  <= '0;
      fc_q  <= '0;
      st_q  <= ST_UNLOCKED;
      ph_q  <= '0;
      run_q <= '0;
      lk_q  <= 1'b0;
    end else begin
      rs_q  <= {rs_q[0], 1'b1};
      fc_q  <= {fc_q[0], fc0_q};
      st_q  <= st_d;
      ph_q  <= ph_d;
      run_q <= run_d;
      lk_q  <= lk_d;
    end
  end
  assign fe  = (fc_q == 2'b01);
  assign ph0 = (ph_q == '0);
  always_comb begin
    st_d  = st_q;
    ph_d  = ph_q + PW'(1);
    run_d = run_q;
    lk_d  = lk_q;
    slip  = 1'b0;
    case (st_q)
      ST_UNLOCKED: if (rs_q[1] && fe) begin
        ph_d  = PW'(1);
        run_d = LW'(1);
        st_d  = ST_HUNT;
      end
      ST_HUNT: if (fe && ph0) begin
        run_d = run_q + LW'(1);
        if (run_d == LW'(LOCK_COUNT)) begin
          st_d = ST_LOCKED;
          lk_d = 1'b1;
        end
      end else if (fe) begin
        ph_d  = PW'(1);
        run_d = LW'(1);
      end else if (ph0) begin
        run_d = '0;
        st_d  = ST_UNLOCKED;
      end
      ST_LOCKED: if (fe != ph0) begin
        // a missing edge keeps counting; a misplaced edge re-aligns immediately
        slip  = 1'b1;
        lk_d  = 1'b0;
        st_d  = ST_HUNT;
        ph_d  = fe ? PW'(1) : ph_d;
        run_d = fe ? LW'(1) : '0;
      end
      default: st_d = ST_UNLOCKED;
    endcase
  end
  assign ph     = ph_q;
  assign locked = lk_q;
endmodule

// File: rtl/truncate_sequencer.sv
// truncate_sequencer: latch enable, slot numbering, overflow and bunch-crossing counters
//   clock/reset   fabric clock, async active-high reset
//   frame_clock   frame clock sampled as data; enable gates latch_en/slot_valid/overflow
//   phase_sel     phase at which latch_en fires; vpfs_any = truncator not drained
//   latch_en, slot_idx, slot_valid, locked, overflow   per-cycle status
//   overflow_cnt, slip_cnt, bx_cnt                       slow-control counters
module truncate_sequencer
  import truncate_sequencer_pkg::*;
#(
  parameter int RATIO      = RATIO_DEF,
  parameter int LOCK_COUNT = LOCK_COUNT_DEF,
  parameter int BX_MAX     = BX_MAX_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     frame_clock,
  input  logic                     enable,
  input  logic [$clog2(RATIO)-1:0] phase_sel,
  input  logic                     vpfs_any,
  output logic                     latch_en,
  output logic [$clog2(RATIO)-1:0] slot_idx,
  output logic                     slot_valid,
  output logic                     locked,
  output logic                     overflow,
  output logic [CNT_W-1:0]         overflow_cnt,
  output logic [7:0]               slip_cnt,
  output logic [11:0]              bx_cnt
);
  localparam int PW = $clog2(RATIO);
  logic [PW-1:0] ph, slot_q, blk_q;
  logic lk, slip, le_d, le_q, sv_q, ov_d, ov_q;
  logic [CNT_W-1:0] ovc_q;
  logic [7:0] slc_q;
  logic [11:0] bx_q;
  frame_phase_detect #(.RATIO(RATIO), .LOCK_COUNT(LOCK_COUNT)) u_phase (
    .clock      (clock),
    .reset      (reset),
    .frame_clock(frame_clock),
    .ph         (ph),
    .locked     (lk),
    .slip       (slip)
  );
  // blk_q holds off a second pulse for RATIO-1 cycles so a phase_sel change cannot double-fire
  assign le_d = lk & enable & ~slip & (ph == phase_sel) & (blk_q == '0);
  assign ov_d = slot_valid & (slot_q == PW'(RATIO - 1)) & vpfs_any;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      le_q   <= 1'b0;
      sv_q   <= 1'b0;
      slot_q <= '0;
      blk_q  <= '0;
      ov_q   <= 1'b0;
      ovc_q  <= '0;
      slc_q  <= '0;
      bx_q   <= '0;
    end else begin
      le_q   <= le_d;
      sv_q   <= lk & enable;
      slot_q <= ph - phase_sel - PW'(1);
      blk_q  <= le_d ? PW'(RATIO - 1) : (blk_q != '0) ? blk_q - PW'(1) : blk_q;
      ov_q   <= ov_d;
      ovc_q  <= ov_d ? CNT_W'(sat_inc(32'(ovc_q), 32'({CNT_W{1'b1}}))) : ovc_q;
      slc_q  <= slip ? 8'(sat_inc(32'(slc_q), 32'd255)) : slc_q;
      bx_q   <= !lk ? '0 : latch_en ? ((bx_q == 12'(BX_MAX)) ? '0 : bx_q + 12'd1) : bx_q;
    end
  end
  assign latch_en     = le_q & enable;
  assign slot_valid   = sv_q & enable;
  assign overflow     = ov_q & enable;
  assign slot_idx     = slot_q;
  assign locked       = lk;
  assign overflow_cnt = ovc_q;
  assign slip_cnt     = slc_q;
  assign bx_cnt       = bx_q;
endmodule

// File: tb/tb_truncate_sequencer.sv
// tb_truncate_sequencer: randomized bench against a frame-edge/anchor reference model
module tb_truncate_sequencer;
  localparam int RATIO = 4, LOCK_COUNT = 8, BX_MAX = 3563, CNT_W = 16;
  logic clock = 1'b0, reset = 1'b1, frame_clock = 1'b0, enable = 1'b0, vpfs_any = 1'b0;
  logic [1:0] phase_sel = 2'd2;
  logic latch_en, slot_valid, locked, overflow;
  logic [1:0] slot_idx;
  logic [CNT_W-1:0] overflow_cnt;
  logic [7:0] slip_cnt;
  logic [11:0] bx_cnt;
  truncate_sequencer #(.RATIO(RATIO), .LOCK_COUNT(LOCK_COUNT), .BX_MAX(BX_MAX), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .frame_clock(frame_clock), .enable(enable),
    .phase_sel(phase_sel), .vpfs_any(vpfs_any), .latch_en(latch_en), .slot_idx(slot_idx),
    .slot_valid(slot_valid), .locked(locked), .overflow(overflow),
    .overflow_cnt(overflow_cnt), .slip_cnt(slip_cnt), .bx_cnt(bx_cnt)
  );
  always #5 clock = ~clock;
  int errors = 0, checks = 0;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask
  // stimulus knobs, applied at each negedge
  bit reset_set = 1'b1, en_set = 1'b0, vpfs_set = 1'b0, rnd_vpfs = 1'b0, stretch_req = 1'b0;
  int ps_set = 2, en_prob = 0, ps_prob = 0, stretch_prob = 0, fk = 0;
  // reference model: phase is measured from an anchor cycle rather than kept as a counter
  int m_s0 = 0, m_s1, m_s2, m_rs, m_cyc, m_anchor, m_mode, m_run, m_lk, m_le, m_sv, m_slot;
  int m_ov, m_ovc, m_slc, m_bx, m_last;
  task automatic model_reset();
    {m_s1, m_s2, m_rs, m_cyc, m_anchor, m_mode, m_run, m_lk} = '0;
    {m_le, m_sv, m_slot, m_ov, m_ovc, m_slc, m_bx} = '0;
    m_last = -1000;
  endtask
  task automatic model_step();
    int ph;
    bit fe, slip, le, lat_out, ovn;
    if (reset) begin
      m_s0 = frame_clock;
      return;
    end
    ph = (m_cyc - m_anchor) % RATIO;
    fe = (m_s2 == 0) && (m_s1 == 1);
    slip = (m_mode == 2) && (fe != (ph == 0));
    le = m_lk && enable && !slip && (ph == int'(phase_sel)) && (m_cyc - m_last >= RATIO);
    lat_out = m_le && enable;
    ovn = m_sv && enable && (m_slot == RATIO - 1) && vpfs_any;
    if (!m_lk) m_bx = 0;
    else if (lat_out) m_bx = (m_bx == BX_MAX) ? 0 : m_bx + 1;
    if (ovn && m_ovc < (1 << CNT_W) - 1) m_ovc++;
    if (slip && m_slc < 255) m_slc++;
    m_ov = ovn;
    m_sv = m_lk && enable;
    m_slot = (ph - int'(phase_sel) - 1 + 2 * RATIO) % RATIO;
    if (le) m_last = m_cyc;
    m_le = le;
    case (m_mode)
      0: if (m_rs >= 2 && fe) begin m_anchor = m_cyc; m_run = 1; m_mode = 1; end
      1: if (fe && ph == 0) begin
           m_run++;
           if (m_run == LOCK_COUNT) begin m_mode = 2; m_lk = 1; end
         end else if (fe) begin m_anchor = m_cyc; m_run = 1; end
         else if (ph == 0) begin m_run = 0; m_mode = 0; end
      default: if (slip) begin
           m_lk = 0;
           m_mode = 1;
           if (fe) begin m_anchor = m_cyc; m_run = 1; end else m_run = 0;
         end
    endcase
    m_s2 = m_s1;
    m_s1 = m_s0;
    m_s0 = frame_clock;
    m_rs = (m_rs < 2) ? m_rs + 1 : 2;
    m_cyc++;
  endtask
  // observation monitors
  int cyc_t = 0, last_le_t = -1, min_gap = 1 << 30, en_low_hits = 0, prev_bx = 0;
  bit prev_latch = 1'b0, seen_wrap = 1'b0;
  task automatic tick();
    @(negedge clock);
    chk("locked", locked, m_lk);
    chk("latch_en", latch_en, m_le && enable);
    chk("slot_idx", slot_idx, m_slot);
    chk("slot_valid", slot_valid, m_sv && enable);
    chk("overflow", overflow, m_ov && enable);
    chk("overflow_cnt", overflow_cnt, m_ovc);
    chk("slip_cnt", slip_cnt, m_slc);
    chk("bx_cnt", bx_cnt, m_bx);
    if (latch_en) begin
      if (last_le_t >= 0 && cyc_t - last_le_t < min_gap) min_gap = cyc_t - last_le_t;
      last_le_t = cyc_t;
    end
    if (prev_latch && locked && prev_bx == BX_MAX && bx_cnt == 0) seen_wrap = 1'b1;
    prev_latch = latch_en;
    prev_bx = bx_cnt;
    if (!enable && (latch_en || overflow)) en_low_hits++;
    cyc_t++;
    reset = reset_set;
    frame_clock = (fk < RATIO / 2);
    if (stretch_req && fk == 1) stretch_req = 1'b0;
    else if (stretch_prob > 0 && $urandom_range(stretch_prob - 1) == 0) fk = fk;
    else fk = (fk + 1) % RATIO;
    if (en_prob > 0 && $urandom_range(en_prob - 1) == 0) en_set = !en_set;
    enable = en_set;
    if (ps_prob > 0 && $urandom_range(ps_prob - 1) == 0) ps_set = $urandom_range(RATIO - 1);
    phase_sel = 2'(ps_set);
    vpfs_any = rnd_vpfs ? 1'($urandom_range(1)) : vpfs_set;
    model_step();
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  int ovc0, bx0;
  initial begin
    model_reset();
    run(3);
    reset_set = 1'b0;
    en_set = 1'b1;
    run(20);
    chk("lock_not_early", locked, 0);
    run(40);
    chk("clean_lock", locked, 1);
    for (int i = 0; i < 20 && !latch_en; i++) tick();
    chk("latch_seen", latch_en, 1);
    for (int i = 0; i < RATIO; i++) begin
      tick();
      chk("slot_seq", slot_idx, i);
    end
    ovc0 = overflow_cnt;
    vpfs_set = 1'b1;
    run(20);
    vpfs_set = 1'b0;
    run(3);
    chk("ovf_five", overflow_cnt - ovc0, 5);
    run(20);
    chk("ovf_none", overflow_cnt - ovc0, 5);
    stretch_req = 1'b1;
    run(12);
    chk("slip_cnt_one", slip_cnt, 1);
    chk("slip_unlocked", locked, 0);
    chk("slip_bx_clr", bx_cnt, 0);
    run(50);
    chk("relock", locked, 1);
    rnd_vpfs = 1'b1;
    run(3564 * RATIO + 40);
    rnd_vpfs = 1'b0;
    en_set = 1'b0;
    tick();
    bx0 = bx_cnt;
    run(9);
    chk("en_low_bx_hold", bx_cnt, bx0);
    en_set = 1'b1;
    run(8);
    chk("en_low_pulses", en_low_hits, 0);
    ps_set = 0;
    run(40);
    rnd_vpfs = 1'b1;
    en_prob = 50;
    ps_prob = 100;
    stretch_prob = 300;
    run(4000);
    {rnd_vpfs, en_prob, ps_prob, stretch_prob} = '0;
    en_set = 1'b1;
    run(2);
    reset_set = 1'b1;
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("arst_locked", locked, 0);
    chk("arst_latch", latch_en, 0);
    chk("arst_slot", slot_idx, 0);
    chk("arst_sv", slot_valid, 0);
    chk("arst_ovf", overflow, 0);
    chk("arst_ovc", overflow_cnt, 0);
    chk("arst_slip", slip_cnt, 0);
    chk("arst_bx", bx_cnt, 0);
    model_reset();
    last_le_t = -1;
    run(3);
    reset_set = 1'b0;
    run(80);
    chk("reacquire", locked, 1);
    chk("min_latch_gap_ok", int'(min_gap >= RATIO), 1);
    chk("bx_wrap_seen", seen_wrap, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
